// File: rtl/pwm_trip_guard.sv
// Output protection between the PWM core and gate-driver pins: registered pass-through,
// filtered external trip and shoot-through detection, latched faults, sync-gated re-enable.
module pwm_trip_guard #(
  parameter int unsigned PWM_WIDTH  = 8,
  parameter int unsigned FILT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PWM_WIDTH-1:0]  pwm_A_in,
  input  logic [PWM_WIDTH-1:0]  pwm_B_in,
  input  logic                  sync_event,
  input  logic                  trip_ext,
  input  logic [FILT_WIDTH-1:0] trip_filter,
  input  logic                  trip_enable,
  input  logic [PWM_WIDTH-1:0]  st_enable,
  input  logic [PWM_WIDTH-1:0]  safe_A,
  input  logic [PWM_WIDTH-1:0]  safe_B,
  input  logic                  fault_clear,
  output logic [PWM_WIDTH-1:0]  pwmout_A,
  output logic [PWM_WIDTH-1:0]  pwmout_B,
  output logic [1:0]            state,
  output logic                  fault_ext,
  output logic [PWM_WIDTH-1:0]  fault_st,
  output logic                  trip_irq
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StTrip    = 2'd1,
    StRecover = 2'd2
  } state_e;

  state_e                  state_q;
  logic [PWM_WIDTH-1:0]    a_q, b_q;
  logic                    sync1_q, s2_q;
  logic [FILT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0]    pwmout_a_q, pwmout_b_q;
  logic                    fault_ext_q, trip_irq_q;
  logic [PWM_WIDTH-1:0]    fault_st_q;

  logic [FILT_WIDTH-1:0]   thr;
  logic                    ext_filt;
  logic [PWM_WIDTH-1:0]    st_hit;
  logic                    trip_now;

  // A zero filter setting behaves as a single-cycle filter.
  assign thr      = (trip_filter == '0) ? FILT_WIDTH'(1) : trip_filter;
  assign ext_filt = (cnt_q >= thr);
  assign st_hit   = st_enable & a_q & b_q;
  assign trip_now = trip_enable & (ext_filt | (|st_hit));

  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q < thr) ? cnt_q + FILT_WIDTH'(1) : thr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRecover;
      a_q         <= '0;
      b_q         <= '0;
      sync1_q     <= 1'b0;
      s2_q        <= 1'b0;
      cnt_q       <= '0;
      pwmout_a_q  <= safe_A;
      pwmout_b_q  <= safe_B;
      fault_ext_q <= 1'b0;
      fault_st_q  <= '0;
      trip_irq_q  <= 1'b0;
    end else begin
      a_q     <= pwm_A_in;
      b_q     <= pwm_B_in;
      sync1_q <= trip_ext;
      s2_q    <= sync1_q;
      cnt_q   <= cnt_d;

      // A trip detected this cycle already blocks the pass-through value.
      if (state_q == StRun && !trip_now) begin
        pwmout_a_q <= a_q;
        pwmout_b_q <= b_q;
      end else begin
        pwmout_a_q <= safe_A;
        pwmout_b_q <= safe_B;
      end

      trip_irq_q <= trip_now & (state_q != StTrip);

      if (trip_enable && (state_q == StTrip || trip_now)) begin
        fault_ext_q <= fault_ext_q | ext_filt;
        fault_st_q  <= fault_st_q | st_hit;
      end

      unique case (state_q)
        StRun: begin
          if (trip_now) state_q <= StTrip;
        end
        StTrip: begin
          if (fault_clear && !trip_now) state_q <= StRecover;
        end
        StRecover: begin
          if (trip_now) begin
            state_q <= StTrip;
          end else if (sync_event) begin
            state_q     <= StRun;
            fault_ext_q <= 1'b0;
            fault_st_q  <= '0;
          end
        end
        default: state_q <= StRecover;
      endcase
    end
  end

  assign pwmout_A  = pwmout_a_q;
  assign pwmout_B  = pwmout_b_q;
  assign state     = state_q;
  assign fault_ext = fault_ext_q;
  assign fault_st  = fault_st_q;
  assign trip_irq  = trip_irq_q;

endmodule

// File: tb/tb_pwm_trip_guard.sv
// Bench for pwm_trip_guard: vector table, directed corner sequences, randomized model check.
module tb_pwm_trip_guard;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pwm_A_in, pwm_B_in;
  logic       sync_event, trip_ext, trip_enable, fault_clear;
  logic [7:0] trip_filter, st_enable, safe_A, safe_B;
  logic [7:0] pwmout_A, pwmout_B, fault_st;
  logic [1:0] state;
  logic       fault_ext, trip_irq;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_trip_guard #(.PWM_WIDTH(8), .FILT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pwm_A_in(pwm_A_in), .pwm_B_in(pwm_B_in),
    .sync_event(sync_event), .trip_ext(trip_ext), .trip_filter(trip_filter),
    .trip_enable(trip_enable), .st_enable(st_enable), .safe_A(safe_A), .safe_B(safe_B),
    .fault_clear(fault_clear), .pwmout_A(pwmout_A), .pwmout_B(pwmout_B), .state(state),
    .fault_ext(fault_ext), .fault_st(fault_st), .trip_irq(trip_irq)
  );

  always #5 clk = ~clk;

  // Reference model: state as 0/1/2, external filter from the run length of raw samples.
  int         m_state;
  logic [7:0] m_aq, m_bq, m_pa, m_pb, m_fs;
  logic       m_fe, m_irq;
  bit         tq[$];

  task automatic model_update();
    int unsigned thr;
    int unsigned run;
    logic        ext, now;
    logic [7:0]  hit;
    if (reset) begin
      m_state = 2; m_pa = safe_A; m_pb = safe_B;
      m_fe = 1'b0; m_fs = '0; m_irq = 1'b0; m_aq = '0; m_bq = '0;
      tq.delete(); tq.push_back(1'b0); tq.push_back(1'b0);
    end else begin
      thr = (trip_filter == 0) ? 1 : int'(trip_filter);
      run = 0;
      // Synchronizer plus counter register: the filter sees samples three edges old.
      for (int j = tq.size() - 3; j >= 0 && tq[j] && run < thr; j--) run++;
      ext = (run >= thr);
      hit = st_enable & m_aq & m_bq;
      now = trip_enable && (ext || hit != 0);
      if (m_state == 0 && !now) begin m_pa = m_aq; m_pb = m_bq; end
      else begin m_pa = safe_A; m_pb = safe_B; end
      m_irq = now && (m_state != 1);
      if (trip_enable && (m_state == 1 || now)) begin
        m_fe = m_fe | ext;
        m_fs = m_fs | hit;
      end
      case (m_state)
        0: if (now) m_state = 1;
        1: if (fault_clear && !now) m_state = 2;
        default: begin
          if (now) m_state = 1;
          else if (sync_event) begin m_state = 0; m_fe = 1'b0; m_fs = '0; end
        end
      endcase
      m_aq = pwm_A_in; m_bq = pwm_B_in;
      tq.push_back(trip_ext);
      if (tq.size() > 300) void'(tq.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rnd pwmout_A", 32'(pwmout_A), 32'(m_pa));
    chk("rnd pwmout_B", 32'(pwmout_B), 32'(m_pb));
    chk("rnd state", 32'(state), 32'(m_state));
    chk("rnd fault_ext", 32'(fault_ext), 32'(m_fe));
    chk("rnd fault_st", 32'(fault_st), 32'(m_fs));
    chk("rnd trip_irq", 32'(trip_irq), 32'(m_irq));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] a, b;
    logic       sync;
    logic [7:0] ste;
    logic [7:0] ea, eb;
    logic [1:0] est;
    logic       eirq;
    logic [7:0] efst;
  } vec_t;

  vec_t vecs[9];

  task automatic random_phase(input logic [7:0] filt, input int cycles);
    trip_filter = filt; reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      pwm_A_in    = 8'($urandom & $urandom & $urandom);
      pwm_B_in    = 8'($urandom & $urandom & $urandom);
      sync_event  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) trip_ext = ~trip_ext;
      trip_enable = ($urandom_range(0, 15) != 0);
      st_enable   = 8'($urandom);
      fault_clear = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        safe_A = 8'($urandom); safe_B = 8'($urandom);
      end
      tick();
      chk_model();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 8'h00, 2'd2, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h0F, 8'hF0, 1'b1, 8'h04, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h0F, 8'hF0, 1'b0, 8'h04, 8'h0F, 8'hF0, 2'd0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h08, 8'h08, 1'b0, 8'h04, 8'h0F, 8'hF0, 2'd0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h04, 8'h08, 8'h08, 2'd0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h04, 8'h04, 1'b0, 8'h04, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 8'h00, 2'd1, 1'b1, 8'h04};
    vecs[7] = '{1'b0, 8'h0F, 8'hF0, 1'b0, 8'h04, 8'h00, 8'h00, 2'd1, 1'b0, 8'h04};
    vecs[8] = '{1'b0, 8'h0F, 8'hF0, 1'b0, 8'h04, 8'h00, 8'h00, 2'd1, 1'b0, 8'h04};

    reset = 1'b1; pwm_A_in = '0; pwm_B_in = '0; sync_event = 1'b0; trip_ext = 1'b0;
    trip_filter = 8'd5; trip_enable = 1'b1; st_enable = 8'h04;
    safe_A = '0; safe_B = '0; fault_clear = 1'b0;

    for (int i = 0; i < 9; i++) begin
      reset = vecs[i].rst; pwm_A_in = vecs[i].a; pwm_B_in = vecs[i].b;
      sync_event = vecs[i].sync; st_enable = vecs[i].ste;
      tick();
      chk($sformatf("vec%0d pwmout_A", i), 32'(pwmout_A), 32'(vecs[i].ea));
      chk($sformatf("vec%0d pwmout_B", i), 32'(pwmout_B), 32'(vecs[i].eb));
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].est));
      chk($sformatf("vec%0d trip_irq", i), 32'(trip_irq), 32'(vecs[i].eirq));
      chk($sformatf("vec%0d fault_st", i), 32'(fault_st), 32'(vecs[i].efst));
    end

    // Clear out of the shoot-through trip, then re-enable on sync.
    safe_A = 8'hA5; safe_B = 8'h5A;
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    chk("clr state", 32'(state), 32'd2);
    chk("clr safe A", 32'(pwmout_A), 32'hA5);
    tick();
    chk("recover hold", 32'(state), 32'd2);
    chk("recover safe B", 32'(pwmout_B), 32'h5A);
    sync_event = 1'b1; tick(); sync_event = 1'b0;
    chk("sync state", 32'(state), 32'd0);
    chk("sync fault_st", 32'(fault_st), 32'h00);
    tick();
    chk("resume A", 32'(pwmout_A), 32'h0F);

    // Filter: a 4-cycle pulse must not trip with filter 5.
    trip_ext = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    trip_ext = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("glitch no trip", 32'(state), 32'd0);
    end
    trip_ext = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      tick();
      chk($sformatf("filt state t%0d", t), 32'(state), (t == 7) ? 32'd1 : 32'd0);
    end
    chk("filt irq", 32'(trip_irq), 32'd1);
    chk("filt fault_ext", 32'(fault_ext), 32'd1);
    chk("filt safe A", 32'(pwmout_A), 32'hA5);
    tick();
    chk("irq one pulse", 32'(trip_irq), 32'd0);

    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    chk("clr ignored", 32'(state), 32'd1);
    trip_ext = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    chk("clr accepted", 32'(state), 32'd2);
    chk("recover fault_ext kept", 32'(fault_ext), 32'd1);
    chk("recover safe", 32'(pwmout_A), 32'hA5);
    sync_event = 1'b1; tick(); sync_event = 1'b0;
    chk("rerun state", 32'(state), 32'd0);
    chk("rerun fault_ext", 32'(fault_ext), 32'd0);

    // Trip and sync arriving together in RECOVER: trip wins.
    pwm_A_in = 8'h04; pwm_B_in = 8'h04; tick();
    pwm_A_in = 8'h0F; pwm_B_in = 8'hF0; tick();
    chk("st2 state", 32'(state), 32'd1);
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    chk("st2 clr", 32'(state), 32'd2);
    pwm_A_in = 8'h04; pwm_B_in = 8'h04; tick();
    chk("sim pre", 32'(state), 32'd2);
    pwm_A_in = 8'h0F; pwm_B_in = 8'hF0; sync_event = 1'b1; tick(); sync_event = 1'b0;
    chk("sim state", 32'(state), 32'd1);
    chk("sim irq", 32'(trip_irq), 32'd1);
    chk("sim safe A", 32'(pwmout_A), 32'hA5);
    chk("sim fault_st", 32'(fault_st), 32'h04);

    // Reset in TRIP drops faults and loads the live safe levels.
    safe_A = 8'h3C; safe_B = 8'hC3;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst state", 32'(state), 32'd2);
    chk("rst fault_st", 32'(fault_st), 32'h00);
    chk("rst fault_ext", 32'(fault_ext), 32'd0);
    chk("rst safe A", 32'(pwmout_A), 32'h3C);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("post rst safe B", 32'(pwmout_B), 32'hC3);
      chk("post rst state", 32'(state), 32'd2);
    end
    sync_event = 1'b1; tick(); sync_event = 1'b0;
    chk("post rst run", 32'(state), 32'd0);
    tick();
    chk("post rst pass", 32'(pwmout_A), 32'h0F);

    random_phase(8'd3, 1500);
    trip_ext = 1'b0;
    random_phase(8'd0, 1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
